// File: rtl/redirect_controller.sv
// redirect_controller: serialises branch/jump and trap redirects to fetch.
// One redirect is offered at a time over valid/ready. IF/ID stay flushed and
// EX stays stalled until fetch accepts and the drain window has elapsed.
// A trap arriving while busy is parked in a one-entry pending slot.
// Optional feature macro: REDIRECT_PERF_EN adds saturating perf counters.
module redirect_controller #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_br_valid,
    input  logic        i_br_taken,
    input  logic [31:0] i_br_target,
    input  logic        i_trap_valid,
    input  logic [31:0] i_trap_target,
    output logic        o_redirect_valid,
    output logic [31:0] o_redirect_pc,
    input  logic        i_redirect_ready,
    output logic        o_flush_if,
    output logic        o_flush_id,
    output logic        o_stall_ex,
    output logic        o_misaligned,
    output logic        o_busy
`ifdef REDIRECT_PERF_EN
    ,
    output logic [31:0] o_perf_redirects,
    output logic [31:0] o_perf_flush_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DRAIN
    } state_t;

    localparam bit         HAS_DRAIN  = (FLUSH_CYCLES != 0);
    localparam logic [3:0] DRAIN_LOAD = HAS_DRAIN ? 4'(FLUSH_CYCLES - 1) : 4'd0;

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_target, w_target_nxt;
    logic        r_pend_valid, w_pend_valid_nxt;
    logic [31:0] r_pend_addr, w_pend_addr_nxt;
    logic        r_misaligned, w_misaligned_nxt;
    logic        r_redirect_valid;
    logic        r_busy;

    // A trap arriving on the very edge the window closes must not be lost,
    // so the exit decision looks at the incoming trap as well (latest wins).
    logic        w_pend_any;
    logic [31:0] w_pend_any_addr;
    assign w_pend_any      = i_trap_valid | r_pend_valid;
    assign w_pend_any_addr = i_trap_valid ? i_trap_target : r_pend_addr;

    // Next-state, next-target, pending-slot and misaligned-pulse logic.
    always_comb begin
        // NOTE: every variable gets a default before the case so that no
        // path leaves it unassigned and no latch is inferred.
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_target_nxt     = r_target;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_addr_nxt  = r_pend_addr;
        w_misaligned_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_trap_valid) begin
                    w_target_nxt = i_trap_target;
                    w_state_nxt  = ST_REQ;
                end else if (i_br_valid && i_br_taken) begin
                    if (i_br_target[1]) begin
                        w_misaligned_nxt = 1'b1;
                    end else begin
                        w_target_nxt = i_br_target & ~32'h1;
                        w_state_nxt  = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (i_trap_valid) begin
                    w_pend_valid_nxt = 1'b1;
                    w_pend_addr_nxt  = i_trap_target;
                end
                if (i_redirect_ready) begin
                    if (HAS_DRAIN) begin
                        w_cnt_nxt   = DRAIN_LOAD;
                        w_state_nxt = ST_DRAIN;
                    end else if (w_pend_any) begin
                        w_target_nxt     = w_pend_any_addr;
                        w_pend_valid_nxt = 1'b0;
                        w_state_nxt      = ST_REQ;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (i_trap_valid) begin
                    w_pend_valid_nxt = 1'b1;
                    w_pend_addr_nxt  = i_trap_target;
                end
                if (r_cnt == 4'd0) begin
                    if (w_pend_any) begin
                        w_target_nxt     = w_pend_any_addr;
                        w_pend_valid_nxt = 1'b0;
                        w_state_nxt      = ST_REQ;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state          <= ST_IDLE;
            r_cnt            <= 4'd0;
            r_target         <= RESET_PC;
            r_pend_valid     <= 1'b0;
            r_pend_addr      <= 32'h0;
            r_misaligned     <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_cnt            <= w_cnt_nxt;
            r_target         <= w_target_nxt;
            r_pend_valid     <= w_pend_valid_nxt;
            r_pend_addr      <= w_pend_addr_nxt;
            r_misaligned     <= w_misaligned_nxt;
            r_redirect_valid <= (w_state_nxt == ST_REQ);
            r_busy           <= (w_state_nxt != ST_IDLE);
        end
    end

    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_target;
    assign o_flush_if       = r_busy;
    assign o_flush_id       = r_busy;
    assign o_stall_ex       = r_busy;
    assign o_misaligned     = r_misaligned;
    assign o_busy           = r_busy;

`ifdef REDIRECT_PERF_EN
    logic [31:0] r_perf_redirects;
    logic [31:0] r_perf_flush_cycles;

    // Saturating counters of accepted redirects and flushed cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_redirects    <= 32'h0;
            r_perf_flush_cycles <= 32'h0;
        end else begin
            if (r_redirect_valid && i_redirect_ready && (r_perf_redirects != 32'hFFFF_FFFF))
                r_perf_redirects <= r_perf_redirects + 32'd1;
            if (r_busy && (r_perf_flush_cycles != 32'hFFFF_FFFF))
                r_perf_flush_cycles <= r_perf_flush_cycles + 32'd1;
        end
    end

    assign o_perf_redirects    = r_perf_redirects;
    assign o_perf_flush_cycles = r_perf_flush_cycles;
`endif

endmodule

// File: tb/tb_redirect_controller.sv
// Self-checking bench for redirect_controller: directed scenarios followed by
// randomized traffic, every cycle compared against a transaction-level model.
module tb_redirect_controller;

    localparam int unsigned FLUSH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        br_valid, br_taken, trap_valid, ready;
    logic [31:0] br_target, trap_target;
    logic        redirect_valid, flush_if, flush_id, stall_ex, misaligned, busy;
    logic [31:0] redirect_pc;
`ifdef REDIRECT_PERF_EN
    logic [31:0] perf_redirects, perf_flush_cycles;
`endif

    redirect_controller #(.FLUSH_CYCLES(FLUSH), .RESET_PC(RESET_PC)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_br_valid       (br_valid),
        .i_br_taken       (br_taken),
        .i_br_target      (br_target),
        .i_trap_valid     (trap_valid),
        .i_trap_target    (trap_target),
        .o_redirect_valid (redirect_valid),
        .o_redirect_pc    (redirect_pc),
        .i_redirect_ready (ready),
        .o_flush_if       (flush_if),
        .o_flush_id       (flush_id),
        .o_stall_ex       (stall_ex),
        .o_misaligned     (misaligned),
        .o_busy           (busy)
`ifdef REDIRECT_PERF_EN
        ,
        .o_perf_redirects    (perf_redirects),
        .o_perf_flush_cycles (perf_flush_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: an offered redirect, a count of flush cycles still owed
    // after acceptance, and a single pending trap slot.
    bit          m_offer;
    int          m_flush_left;
    logic [31:0] m_pc;
    bit          m_pend_v;
    logic [31:0] m_pend_a;
    bit          m_mis;
    longint      m_perf_red, m_perf_fl;

    function automatic logic [31:0] sat32(input longint v);
        return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
    endfunction

    task automatic model_edge();
        m_mis = 1'b0;
        if (rst) begin
            m_offer = 0; m_flush_left = 0; m_pc = RESET_PC; m_pend_v = 0;
            m_perf_red = 0; m_perf_fl = 0;
            return;
        end
        if (m_offer || m_flush_left > 0) m_perf_fl++;
        if (m_offer && ready) m_perf_red++;
        if (m_offer) begin
            if (trap_valid) begin m_pend_v = 1; m_pend_a = trap_target; end
            if (ready) begin
                m_offer = 0;
                m_flush_left = FLUSH;
                if (FLUSH == 0 && m_pend_v) begin
                    m_offer = 1; m_pc = m_pend_a; m_pend_v = 0;
                end
            end
        end else if (m_flush_left > 0) begin
            if (trap_valid) begin m_pend_v = 1; m_pend_a = trap_target; end
            m_flush_left--;
            if (m_flush_left == 0 && m_pend_v) begin
                m_offer = 1; m_pc = m_pend_a; m_pend_v = 0;
            end
        end else begin
            if (trap_valid) begin
                m_offer = 1; m_pc = trap_target;
            end else if (br_valid && br_taken) begin
                if (br_target[1]) m_mis = 1;
                else begin m_offer = 1; m_pc = {br_target[31:1], 1'b0}; end
            end
        end
    endtask

    task automatic compare_all();
        bit exp_busy;
        exp_busy = m_offer || (m_flush_left > 0);
        check("redirect_valid", {31'b0, redirect_valid}, {31'b0, m_offer});
        check("redirect_pc", redirect_pc, m_pc);
        check("flush_if", {31'b0, flush_if}, {31'b0, exp_busy});
        check("flush_id", {31'b0, flush_id}, {31'b0, exp_busy});
        check("stall_ex", {31'b0, stall_ex}, {31'b0, exp_busy});
        check("misaligned", {31'b0, misaligned}, {31'b0, m_mis});
        check("busy", {31'b0, busy}, {31'b0, exp_busy});
`ifdef REDIRECT_PERF_EN
        check("perf_redirects", perf_redirects, sat32(m_perf_red));
        check("perf_flush_cycles", perf_flush_cycles, sat32(m_perf_fl));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        br_valid = 0; br_taken = 0; trap_valid = 0;
    endtask

    task automatic branch(input logic [31:0] t);
        br_valid = 1; br_taken = 1; br_target = t;
    endtask

    initial begin
        rst = 1; ready = 1; br_target = 0; trap_target = 0;
        idle_inputs();
        m_pend_a = 0; m_pc = RESET_PC;
        step(); step();
        rst = 0;
        check("reset_pc", redirect_pc, RESET_PC);
        check("reset_busy", {31'b0, busy}, 32'd0);

        // Taken branch with ready high.
        branch(32'h0000_0104); step(); idle_inputs();
        check("br_valid", {31'b0, redirect_valid}, 32'd1);
        check("br_pc", redirect_pc, 32'h0000_0104);
        step(); step();
        check("br_drain_flush", {31'b0, flush_if}, 32'd1);
        step();
        check("br_busy_clear", {31'b0, busy}, 32'd0);

        // Backpressure: ready low for five cycles.
        ready = 0; branch(32'h0000_0200); step(); idle_inputs();
        for (int i = 0; i < 4; i++) begin
            step();
            check("bp_pc_stable", redirect_pc, 32'h0000_0200);
        end
        ready = 1; step(); step(); step(); step();

        // Misaligned target and not-taken branch.
        branch(32'h0000_0102); step(); idle_inputs();
        check("mis_pulse", {31'b0, misaligned}, 32'd1);
        br_valid = 1; br_taken = 0; br_target = 32'h0000_0700; step(); idle_inputs();
        check("mis_one_cycle", {31'b0, misaligned}, 32'd0);
        check("not_taken_idle", {31'b0, busy}, 32'd0);

        // Trap arriving during DRAIN, then a branch ignored while busy.
        branch(32'h0000_0300); step(); idle_inputs();
        step();
        trap_valid = 1; trap_target = 32'h8000_0000; step(); idle_inputs();
        step();
        check("trap_req_valid", {31'b0, redirect_valid}, 32'd1);
        check("trap_req_pc", redirect_pc, 32'h8000_0000);
        branch(32'h0000_0900); step(); idle_inputs();
        step(); step();

        // Simultaneous trap and taken branch in IDLE.
        branch(32'h0000_0400); trap_valid = 1; trap_target = 32'h9000_0000; step(); idle_inputs();
        check("simul_pc", redirect_pc, 32'h9000_0000);
        step(); step(); step();

        // Reset while in REQ, then a normal branch.
        ready = 0; branch(32'h0000_0500); step(); idle_inputs();
        rst = 1; step(); rst = 0;
        check("rst_req_valid", {31'b0, redirect_valid}, 32'd0);
        check("rst_req_pc", redirect_pc, RESET_PC);
        ready = 1; branch(32'h0000_0601); step(); idle_inputs();
        check("post_rst_pc", redirect_pc, 32'h0000_0600);
        step(); step(); step();

        // Three accepted redirects from reset for the perf counters.
        rst = 1; step(); rst = 0;
        for (int i = 0; i < 3; i++) begin
            branch(32'h0000_1000 + 32'(i) * 32'h10); step(); idle_inputs();
            step(); step(); step();
        end
`ifdef REDIRECT_PERF_EN
        check("perf_red_3", perf_redirects, 32'd3);
        check("perf_fl_9", perf_flush_cycles, 32'd9);
`endif

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            rst         = ($urandom_range(0, 99) == 0);
            br_valid    = $urandom_range(0, 1) == 1;
            br_taken    = $urandom_range(0, 2) != 0;
            br_target   = $urandom;
            trap_valid  = ($urandom_range(0, 7) == 0);
            trap_target = $urandom;
            ready       = $urandom_range(0, 2) != 0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
